icache_fill_ctrl: RTL

- Instruction-cache controller that serves the fetch queue's 128-bit line requests.
- Holds a direct-mapped tag/valid/data array.
- On a miss, sequences a refill from the memory interface, then returns the line on Dout/Dout_valid.
- Sits between the fetch queue (Pc_in/Rd_en_cache/Dout/Dout_valid/Jmp_branch_valid) and the instruction memory port.

---
 rtl/icache_fill_ctrl.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/icache_fill_ctrl.sv
// ----------------------------------------------------------------------------
// icache_fill_ctrl
//   Direct-mapped instruction cache front end for the fetch queue. A request
//   that hits returns its 128-bit line on the next cycle. A request that
//   misses is refilled from the instruction memory port, written into the
//   array, and then returned one cycle after Mem_ack. A redirect
//   (Jmp_branch_valid) kills the pending response but never the memory
//   transaction. Inv_all clears every valid bit with a one-line-per-cycle
//   sweep.
//
// Ports
//   clk              clock, all logic on posedge
//   reset            synchronous, active-low
//   Pc_in            fetch line address, bits [3:0] ignored
//   Rd_en_cache      fetch request qualifier for Pc_in
//   Jmp_branch_valid redirect / flush of any pending response
//   Dout             returned line, word0 in [127:96]
//   Dout_valid       one-cycle pulse marking Dout valid
//   Mem_req          refill request, held until Mem_ack
//   Mem_addr         refill line address {tag, index, 4'b0}
//   Mem_ack          memory returns Mem_data this cycle
//   Mem_data         refill line
//   Inv_all          pulse: invalidate the whole cache
//   Busy             high whenever the controller is not IDLE
//   Miss_count       saturating miss counter since reset
// ----------------------------------------------------------------------------
module icache_fill_ctrl #(
  parameter int LINES = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Pc_in,
  input  logic             Rd_en_cache,
  input  logic             Jmp_branch_valid,
  output logic [127:0]     Dout,
  output logic             Dout_valid,
  output logic             Mem_req,
  output logic [31:0]      Mem_addr,
  input  logic             Mem_ack,
  input  logic [127:0]     Mem_data,
  input  logic             Inv_all,
  output logic             Busy,
  output logic [CNT_W-1:0] Miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    MISS,
    RESP,
    INVAL
  } state_t;

  state_t state, state_nxt;

  // Line storage. Only the valid bits need a reset value; tag and data are
  // qualified by valid before they are ever used.
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [127:0]     data_mem [LINES];

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;

  logic             dv_q;
  logic             drop;
  logic             inv_pending;
  logic [IDX_W-1:0] inv_cnt;

  // Control strobes decoded by the FSM for the datapath.
  logic accept;
  logic hit;
  logic miss_start;
  logic fill;
  logic inv_start;
  logic inv_last;
  logic in_refill;

  assign req_idx  = Pc_in[IDX_W+3:4];
  assign req_tag  = Pc_in[31:IDX_W+4];
  // Mem_addr is held stable for the whole miss, so it doubles as the
  // refill index/tag register.
  assign fill_idx = Mem_addr[IDX_W+3:4];
  assign fill_tag = Mem_addr[31:IDX_W+4];

  assign inv_last  = (inv_cnt == IDX_W'(LINES - 1));
  assign in_refill = (state == MISS) || (state == RESP);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and strobes
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    hit        = 1'b0;
    miss_start = 1'b0;
    fill       = 1'b0;
    inv_start  = 1'b0;

    case (state)
      IDLE: begin
        // Invalidate wins over a same-cycle request.
        if (Inv_all) begin
          inv_start = 1'b1;
          state_nxt = INVAL;
        end else if (Rd_en_cache && !Jmp_branch_valid && !inv_pending) begin
          accept = 1'b1;
          hit    = valid[req_idx] && (tag_mem[req_idx] == req_tag);
          if (!hit) begin
            miss_start = 1'b1;
            state_nxt  = MISS;
          end
        end
      end

      MISS: begin
        if (Mem_ack) begin
          fill      = 1'b1;
          state_nxt = RESP;
        end
      end

      RESP: begin
        // An Inv_all arriving in the RESP cycle itself is folded in here
        // rather than waiting for inv_pending to register.
        if (inv_pending || Inv_all) begin
          inv_start = 1'b1;
          state_nxt = INVAL;
        end else begin
          state_nxt = IDLE;
        end
      end

      INVAL: begin
        if (inv_last) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign Busy = (state != IDLE);

  // A redirect in the cycle a response is presented suppresses it.
  assign Dout_valid = dv_q && !Jmp_branch_valid;

  // --------------------------------------------------------------------------
  // Datapath and control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid       <= '0;
      Dout        <= '0;
      dv_q        <= 1'b0;
      Mem_req     <= 1'b0;
      Mem_addr    <= '0;
      Miss_count  <= '0;
      inv_pending <= 1'b0;
      drop        <= 1'b0;
      inv_cnt     <= '0;
    end else begin
      dv_q <= 1'b0;

      if (accept && hit) begin
        Dout <= data_mem[req_idx];
        dv_q <= 1'b1;
      end

      if (miss_start) begin
        Mem_req  <= 1'b1;
        Mem_addr <= {Pc_in[31:4], 4'b0000};
        if (Miss_count != '1) begin
          Miss_count <= Miss_count + CNT_W'(1);
        end
      end

      if (fill) begin
        Mem_req         <= 1'b0;
        valid[fill_idx] <= 1'b1;
        // A redirect on the ack cycle is treated like an earlier one.
        if (!drop && !Jmp_branch_valid) begin
          Dout <= Mem_data;
          dv_q <= 1'b1;
        end
      end

      if (in_refill && Jmp_branch_valid) begin
        drop <= 1'b1;
      end
      // RESP retires the transaction; its clear overrides a same-cycle set.
      if (state == RESP) begin
        drop <= 1'b0;
      end

      if (in_refill && Inv_all) begin
        inv_pending <= 1'b1;
      end

      if (inv_start) begin
        inv_cnt <= '0;
      end

      if (state == INVAL) begin
        valid[inv_cnt] <= 1'b0;
        inv_cnt        <= inv_cnt + IDX_W'(1);
        if (inv_last) begin
          inv_pending <= 1'b0;
        end
      end
    end
  end

  // Tag/data write port, used only by refills.
  always_ff @(posedge clk) begin
    if (reset && fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= Mem_data;
    end
  end

endmodule
